// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read, writeback, issue and flush signals between the pipeline and the register file
interface regfile_scoreboard_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [AW:0]         pend_cnt;
    modport master (output rs_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr, flush,
                    input rs_data, rs_busy, pend_cnt);
    modport slave  (input rs_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr, flush,
                    output rs_data, rs_busy, pend_cnt);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with write-through bypass, hardwired x0 and pending-write scoreboard
module regfile_scoreboard #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_scoreboard_if.slave   bus
);
    logic [XLEN-1:0]     r_regs [NREGS];
    logic [NREGS-1:0]    r_pend;
    logic [AW:0]         r_cnt;
    logic                w_wr;
    logic                w_set;
    logic                w_inc;
    logic                w_dec;
    logic [AW-1:0]       w_a;
    logic [NRD*XLEN-1:0] w_rd;
    logic [NRD-1:0]      w_busy;

    assign w_wr  = bus.wb_en && bus.wb_addr != '0;
    assign w_set = bus.iss_en && bus.iss_addr != '0;
    assign w_inc = w_set && !r_pend[bus.iss_addr];
    // a release is cancelled when the same register is re-reserved in this cycle
    assign w_dec = w_wr && r_pend[bus.wb_addr] && !(w_set && bus.iss_addr == bus.wb_addr);

    always_comb begin
        w_rd   = '0;
        w_busy = '0;
        w_a    = '0;
        for (int i = 0; i < NRD; i++) begin
            w_a = bus.rs_addr[i*AW +: AW];
            w_rd[i*XLEN +: XLEN] = (reset || w_a == '0) ? '0 :
                                   (bus.wb_en && bus.wb_addr == w_a) ? bus.wb_data : r_regs[w_a];
            w_busy[i] = !reset && r_pend[w_a] && !(bus.wb_en && bus.wb_addr == w_a);
        end
    end

    assign bus.rs_data  = w_rd;
    assign bus.rs_busy  = w_busy;
    assign bus.pend_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // later set overrides earlier clear, so a same-address reserve wins
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) r_pend[bus.wb_addr] <= 1'b0;
            if (w_set) r_pend[bus.iss_addr] <= 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
        end
    end
endmodule
